segasys1_dectbl_loader: RTL and testbench

- Download-side stage directly upstream of the System 1 program-ROM decryptor.
- Watches the ROM download byte stream and extracts the 256-byte decryption-table window.
- Re-issues the window bytes as registered table write strobes into the decryptor's two 128-entry table RAMs.
- Classifies the cartridge as plain, type-1 or type-2 at end of download. Its mode output replaces the decryptor's free-running detect counters.

---
 rtl/segasys1_dectbl_loader.sv | 154 +++++++++++++++
 tb/tb_segasys1_dectbl_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/segasys1_dectbl_loader.sv
// Extracts the 256-byte decryption-table window from the ROM download stream,
// replays it as table RAM writes and classifies the cartridge at end of download.
module segasys1_dectbl_loader #(
  parameter logic [24:0] TBL_BASE = 25'h58400,
  parameter logic [1:0]  MODE_RST = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dl_active,
  input  logic [24:0] ROMAD,
  input  logic [7:0]  ROMDT,
  input  logic        ROMEN,
  output logic        tbl_we,
  output logic        tbl_sel,
  output logic [6:0]  tbl_ad,
  output logic [7:0]  tbl_dt,
  output logic [1:0]  dec_mode,
  output logic        mode_valid
);

  // state | meaning
  // IDLE  | no download seen since reset
  // LOAD  | download in progress, statistics accumulating
  // CHECK | one-cycle classification of the finished download
  // DONE  | dec_mode valid, waiting for the next download
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [24:0] TBL_END = TBL_BASE + 25'd255;
  localparam logic [7:0]  BASE_LO = TBL_BASE[7:0];

  logic [1:0] state_q, state_d;
  logic       dl_q, armed_q, pend_q, pend_d;
  logic       tbl_we_q, tbl_sel_q;
  logic [6:0] tbl_ad_q;
  logic [7:0] tbl_dt_q;
  logic [1:0] dec_mode_q, dec_mode_d;
  logic       mode_valid_q, mode_valid_d;
  logic [8:0] cnt_all_q, cnt_zero_q, cnt_small_q;
  logic       in_win, rise, fall, start_req, start;
  logic [7:0] off;
  logic       inc_all, inc_zero, inc_small;

  // armed_q blocks a false rise when reset releases while dl_active is still high
  assign rise      = dl_active & ~dl_q & armed_q;
  assign fall      = ~dl_active & dl_q;
  assign start_req = rise | (pend_q & dl_active);

  assign in_win    = ROMEN & dl_active & (ROMAD >= TBL_BASE) & (ROMAD <= TBL_END);
  assign off       = ROMAD[7:0] - BASE_LO;
  assign inc_all   = in_win;
  assign inc_zero  = in_win & (ROMDT == 8'd0);
  assign inc_small = in_win & off[7] & (ROMDT < 8'd24);

  function automatic logic [8:0] sat_inc(input logic [8:0] c, input logic inc);
    return (inc && c != 9'd511) ? c + 9'd1 : c;
  endfunction

  always_comb begin
    state_d      = state_q;
    dec_mode_d   = dec_mode_q;
    mode_valid_d = mode_valid_q;
    pend_d       = pend_q;
    start        = 1'b0;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (start_req) begin
          start        = 1'b1;
          mode_valid_d = 1'b0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (fall) state_d = CHECK;
      end
      CHECK: begin
        if (cnt_all_q < 9'd256)        dec_mode_d = 2'd0;
        else if (cnt_zero_q >= 9'd256) dec_mode_d = 2'd0;
        else if (cnt_small_q >= 9'd128) dec_mode_d = 2'd2;
        else                           dec_mode_d = 2'd1;
        if (rise) pend_d = 1'b1;
        state_d = DONE;
      end
      default: begin
        pend_d = 1'b0;
        if (start_req) begin
          start        = 1'b1;
          mode_valid_d = 1'b0;
          state_d      = LOAD;
        end else begin
          mode_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dl_q         <= 1'b0;
      armed_q      <= 1'b0;
      pend_q       <= 1'b0;
      dec_mode_q   <= MODE_RST;
      mode_valid_q <= 1'b0;
      cnt_all_q    <= '0;
      cnt_zero_q   <= '0;
      cnt_small_q  <= '0;
    end else begin
      state_q      <= state_d;
      dl_q         <= dl_active;
      armed_q      <= armed_q | ~dl_active;
      pend_q       <= pend_d;
      dec_mode_q   <= dec_mode_d;
      mode_valid_q <= mode_valid_d;
      // a byte arriving on the rising-edge cycle belongs to the new download
      if (start) begin
        cnt_all_q   <= {8'd0, inc_all};
        cnt_zero_q  <= {8'd0, inc_zero};
        cnt_small_q <= {8'd0, inc_small};
      end else if (state_q == LOAD) begin
        cnt_all_q   <= sat_inc(cnt_all_q, inc_all);
        cnt_zero_q  <= sat_inc(cnt_zero_q, inc_zero);
        cnt_small_q <= sat_inc(cnt_small_q, inc_small);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_we_q  <= 1'b0;
      tbl_sel_q <= 1'b0;
      tbl_ad_q  <= '0;
      tbl_dt_q  <= '0;
    end else begin
      tbl_we_q <= in_win;
      if (in_win) begin
        tbl_sel_q <= off[7];
        tbl_ad_q  <= off[6:0];
        tbl_dt_q  <= ROMDT;
      end
    end
  end

  assign tbl_we     = tbl_we_q;
  assign tbl_sel    = tbl_sel_q;
  assign tbl_ad     = tbl_ad_q;
  assign tbl_dt     = tbl_dt_q;
  assign dec_mode   = dec_mode_q;
  assign mode_valid = mode_valid_q;

endmodule

// File: tb/tb_segasys1_dectbl_loader.sv
// Scoreboard bench: table writes queued at drive time and matched on tbl_we,
// download classification and mode_valid timing checked after each download.
module tb_segasys1_dectbl_loader;
  localparam logic [24:0] TB = 25'h58400;

  logic        clk = 1'b0;
  logic        rst_n, dl_active, ROMEN;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        tbl_we, tbl_sel;
  logic [6:0]  tbl_ad;
  logic [7:0]  tbl_dt;
  logic [1:0]  dec_mode;
  logic        mode_valid;

  int n_checks = 0;
  int n_errors = 0;
  int n_we = 0;
  int n_pushed = 0;
  logic [15:0] exp_q[$];

  segasys1_dectbl_loader #(.TBL_BASE(TB), .MODE_RST(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .dl_active(dl_active),
    .ROMAD(ROMAD), .ROMDT(ROMDT), .ROMEN(ROMEN),
    .tbl_we(tbl_we), .tbl_sel(tbl_sel), .tbl_ad(tbl_ad), .tbl_dt(tbl_dt),
    .dec_mode(dec_mode), .mode_valid(mode_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tbl_we) begin
      n_we++;
      if (exp_q.size() == 0) check_eq("unexpected_we", 32'd1, 32'd0);
      else check_eq("tbl_write", {16'd0, tbl_sel, tbl_ad, tbl_dt}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data);
    logic [7:0] off;
    @(posedge clk); #1;
    ROMEN = 1'b1; ROMAD = addr; ROMDT = data;
    if (dl_active && addr >= TB && addr <= TB + 25'd255) begin
      off = 8'(addr - TB);
      exp_q.push_back({off[7], off[6:0], data});
      n_pushed++;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    ROMEN = 1'b0;
  endtask

  task automatic dl_start();
    @(posedge clk); #1;
    dl_active = 1'b1; ROMEN = 1'b0;
    @(posedge clk); #1;
    check_eq("mv_drop", {31'd0, mode_valid}, 32'd0);
  endtask

  task automatic finish_dl(input bit coincide, input bit valid_exp, input logic [1:0] mode_exp);
    @(posedge clk); #1;
    dl_active = 1'b0;
    ROMEN = coincide; ROMAD = TB + 25'd5; ROMDT = 8'h33;
    @(posedge clk); #1;
    ROMEN = 1'b0;
    check_eq("mv_low_e0", {31'd0, mode_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("mv_low_e1", {31'd0, mode_valid}, 32'd0);
    @(posedge clk); #1;
    check_eq("mode_valid", {31'd0, mode_valid}, {31'd0, valid_exp});
    check_eq("dec_mode", {30'd0, dec_mode}, {30'd0, mode_exp});
    check_eq("sb_empty", exp_q.size(), 32'd0);
  endtask

  function automatic logic [7:0] pat(input int kind, input int i);
    logic [7:0] v;
    case (kind)
      1: v = 8'(i + 1);
      2: v = (i < 128) ? 8'(i + 1) : 8'((i % 128) % 24);
      default: v = 8'd0;
    endcase
    return v;
  endfunction

  task automatic download(input int kind, input int n, input bit coincide, input logic [1:0] mode_exp);
    dl_start();
    for (int i = 0; i < n; i++) send_byte(TB + 25'(i), pat(kind, i));
    finish_dl(coincide, 1'b1, mode_exp);
  endtask

  initial begin
    rst_n = 1'b0; dl_active = 1'b0; ROMEN = 1'b0; ROMAD = '0; ROMDT = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_we", {31'd0, tbl_we}, 32'd0);
    check_eq("rst_sel_ad_dt", {16'd0, tbl_sel, tbl_ad, tbl_dt}, 32'd0);
    check_eq("rst_mode", {30'd0, dec_mode}, 32'd0);
    check_eq("rst_mv", {31'd0, mode_valid}, 32'd0);
    rst_n = 1'b1;

    download(1, 256, 1'b0, 2'd1);

    // reset in the middle of a download; its tail must not yield a mode
    dl_start();
    for (int i = 0; i < 100; i++) send_byte(TB + 25'(i), pat(1, i));
    idle_cycle();
    idle_cycle();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_eq("abort_we", {31'd0, tbl_we}, 32'd0);
    check_eq("abort_sel_ad_dt", {16'd0, tbl_sel, tbl_ad, tbl_dt}, 32'd0);
    check_eq("abort_mode", {30'd0, dec_mode}, 32'd0);
    check_eq("abort_mv", {31'd0, mode_valid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 100; i < 256; i++) send_byte(TB + 25'(i), pat(1, i));
    finish_dl(1'b0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("abort_mv_late", {31'd0, mode_valid}, 32'd0);

    download(2, 256, 1'b0, 2'd2);
    download(0, 256, 1'b0, 2'd0);
    download(1, 255, 1'b0, 2'd0);

    // bytes while dl_active is low are ignored
    for (int i = 0; i < 3; i++) send_byte(TB + 25'(i), 8'h55);
    idle_cycle();
    dl_start();
    send_byte(TB - 25'd1, 8'hAA);
    send_byte(TB + 25'd256, 8'hBB);
    send_byte(TB, 8'hCC);
    send_byte(TB + 25'd255, 8'hDD);
    finish_dl(1'b0, 1'b1, 2'd0);

    dl_start();
    finish_dl(1'b0, 1'b1, 2'd0);

    download(1, 256, 1'b0, 2'd1);
    download(0, 256, 1'b1, 2'd0);

    idle_cycle();
    idle_cycle();
    check_eq("we_total", n_we, n_pushed);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
